// File: rtl/nibble_core_p.sv
// Two-phase accumulator CPU with external ROM/RAM and a DATA_W-wide datapath.
// Define CALL_STACK_EN to get CALL/RET on a hardware return-address stack.
module nibble_core_p #(
    parameter int DATA_W      = 4,
    parameter int STACK_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    output logic [11:0]       rom_addr,
    input  logic [7:0]        rom_data,
    output logic [11:0]       ram_addr,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] pushbuttons,
    output logic [DATA_W-1:0] out_port,
    output logic              out_valid,
    output logic              phase,
    output logic              c_flag,
    output logic              z_flag,
    output logic [DATA_W-1:0] accu,
    output logic [11:0]       pc,
    output logic [3:0]        instr,
    output logic [3:0]        oprnd,
    output logic              stack_err
);

    localparam logic [3:0] OP_JC   = 4'h0, OP_JNC = 4'h1, OP_CMPI = 4'h2, OP_CMPM = 4'h3;
    localparam logic [3:0] OP_LIT  = 4'h4, OP_IN  = 4'h5, OP_LD   = 4'h6, OP_ST   = 4'h7;
    localparam logic [3:0] OP_JZ   = 4'h8, OP_JNZ = 4'h9, OP_ADDI = 4'hA, OP_ADDM = 4'hB;
    localparam logic [3:0] OP_JMP  = 4'hC, OP_OUT = 4'hD, OP_NANDI = 4'hE, OP_F   = 4'hF;

    logic              phase_q, phase_d;
    logic [11:0]       pc_q, pc_d;
    logic [3:0]        instr_q, instr_d;
    logic [3:0]        oprnd_q, oprnd_d;
    logic [DATA_W-1:0] accu_q, accu_d;
    logic              c_q, c_d, z_q, z_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic              out_valid_q, out_valid_d;
    logic              stack_err_q, stack_err_d;
    logic              we;

    logic [DATA_W-1:0] imm;
    logic [11:0]       pc_inc;
    logic [11:0]       jump_tgt;
    logic [DATA_W:0]   res;
    logic              upd_flags;
    logic              wr_accu;

    assign imm      = DATA_W'(oprnd_q);
    assign pc_inc   = pc_q + 12'd1;
    assign jump_tgt = {oprnd_q, rom_data};

`ifdef CALL_STACK_EN
    localparam int SP_W = $clog2(STACK_DEPTH + 1);
    logic [SP_W-1:0] sp_q, sp_d;
    logic [SP_W-1:0] sp_m1;
    logic [11:0]     stack_q [0:(1<<SP_W)-1];
    logic            push_en;

    assign sp_m1 = sp_q - SP_W'(1);

    // One register per stack slot; only the slot at sp is written on a push.
    for (genvar gi = 0; gi < (1 << SP_W); gi++) begin : g_stack
        always_ff @(posedge clock) begin
            if (reset)
                stack_q[gi] <= '0;
            else if (push_en && sp_q == SP_W'(gi))
                stack_q[gi] <= pc_inc;
        end
    end

    always_ff @(posedge clock) begin
        if (reset)
            sp_q <= '0;
        else
            sp_q <= sp_d;
    end
`endif

    always_comb begin
        phase_d     = ~phase_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        oprnd_d     = oprnd_q;
        accu_d      = accu_q;
        c_d         = c_q;
        z_d         = z_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        stack_err_d = stack_err_q;
        we          = 1'b0;
        res         = '0;
        upd_flags   = 1'b0;
        wr_accu     = 1'b0;
`ifdef CALL_STACK_EN
        sp_d        = sp_q;
        push_en     = 1'b0;
`endif
        if (!phase_q) begin
            {instr_d, oprnd_d} = rom_data;
            pc_d               = pc_inc;
        end else begin
            case (instr_q)
                OP_JC:   pc_d = c_q  ? jump_tgt : pc_inc;
                OP_JNC:  pc_d = !c_q ? jump_tgt : pc_inc;
                OP_JZ:   pc_d = z_q  ? jump_tgt : pc_inc;
                OP_JNZ:  pc_d = !z_q ? jump_tgt : pc_inc;
                OP_CMPI: begin
                    res       = {1'b0, accu_q} - {1'b0, imm};
                    upd_flags = 1'b1;
                end
                OP_CMPM: begin
                    res       = {1'b0, accu_q} - {1'b0, ram_rdata};
                    upd_flags = 1'b1;
                    pc_d      = pc_inc;
                end
                OP_LIT: begin
                    res       = {1'b0, imm};
                    upd_flags = 1'b1;
                    wr_accu   = 1'b1;
                end
                OP_IN: begin
                    res       = {1'b0, pushbuttons};
                    upd_flags = 1'b1;
                    wr_accu   = 1'b1;
                end
                OP_LD: begin
                    res       = {1'b0, ram_rdata};
                    upd_flags = 1'b1;
                    wr_accu   = 1'b1;
                    pc_d      = pc_inc;
                end
                OP_ST: begin
                    we   = 1'b1;
                    pc_d = pc_inc;
                end
                OP_ADDI: begin
                    res       = {1'b0, accu_q} + {1'b0, imm};
                    upd_flags = 1'b1;
                    wr_accu   = 1'b1;
                end
                OP_ADDM: begin
                    res       = {1'b0, accu_q} + {1'b0, ram_rdata};
                    upd_flags = 1'b1;
                    wr_accu   = 1'b1;
                    pc_d      = pc_inc;
                end
                OP_JMP: pc_d = jump_tgt;
                OP_OUT: begin
`ifdef CALL_STACK_EN
                    if (oprnd_q[0]) begin
                        // RET on an empty stack leaves pc where the fetch put it.
                        if (sp_q == '0) begin
                            stack_err_d = 1'b1;
                        end else begin
                            pc_d = stack_q[sp_m1];
                            sp_d = sp_m1;
                        end
                    end else begin
                        out_d       = accu_q;
                        out_valid_d = 1'b1;
                    end
`else
                    out_d       = accu_q;
                    out_valid_d = 1'b1;
`endif
                end
                OP_NANDI: begin
                    res       = {1'b0, ~(accu_q & imm)};
                    upd_flags = 1'b1;
                    wr_accu   = 1'b1;
                end
                OP_F: begin
`ifdef CALL_STACK_EN
                    if (sp_q == SP_W'(STACK_DEPTH)) begin
                        stack_err_d = 1'b1;
                        pc_d        = pc_inc;
                    end else begin
                        push_en = 1'b1;
                        sp_d    = sp_q + SP_W'(1);
                        pc_d    = jump_tgt;
                    end
`else
                    res       = {1'b0, ~(accu_q & ram_rdata)};
                    upd_flags = 1'b1;
                    wr_accu   = 1'b1;
                    pc_d      = pc_inc;
`endif
                end
                default: ;
            endcase
            if (upd_flags) begin
                c_d = res[DATA_W];
                z_d = (res[DATA_W-1:0] == '0);
            end
            if (wr_accu)
                accu_d = res[DATA_W-1:0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            phase_q     <= 1'b0;
            pc_q        <= '0;
            instr_q     <= '0;
            oprnd_q     <= '0;
            accu_q      <= '0;
            c_q         <= 1'b0;
            z_q         <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            stack_err_q <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            oprnd_q     <= oprnd_d;
            accu_q      <= accu_d;
            c_q         <= c_d;
            z_q         <= z_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            stack_err_q <= stack_err_d;
        end
    end

    // Reset suppresses the strobe so a reset edge never commits a store.
    assign ram_we    = we & ~reset;
    assign rom_addr  = pc_q;
    assign ram_addr  = jump_tgt;
    assign ram_wdata = accu_q;
    assign out_port  = out_q;
    assign out_valid = out_valid_q;
    assign phase     = phase_q;
    assign c_flag    = c_q;
    assign z_flag    = z_q;
    assign accu      = accu_q;
    assign pc        = pc_q;
    assign instr     = instr_q;
    assign oprnd     = oprnd_q;
`ifdef CALL_STACK_EN
    assign stack_err = stack_err_q;
`else
    assign stack_err = 1'b0;
`endif

endmodule
